// File: rtl/instr_fetch_pkg.sv
// Shared types and AXI constants for the instruction prefetch path.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/instr_axi_prefetch_if.sv
// AXI4 read-channel bundle (AR + R) between the prefetcher and instruction BRAM.
interface instr_axi_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/sync_fifo.sv
// Prefetch FIFO with a registered output stage; o_count includes the output register.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic                       o_rd_valid,
  output logic [DATA_W-1:0]          o_rd_data,
  input  logic                       i_rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_mem_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Refill the output stage whenever it is empty or being consumed this cycle.
  assign w_pop = (r_mem_cnt != '0) && (!r_out_valid || i_rd_ready);

  always_ff @(posedge clk) begin
    if (i_wr_en && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({i_wr_en, w_pop})
        2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
        2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[r_rd_ptr];
      end else if (i_rd_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_rd_valid = r_out_valid;
  assign o_rd_data  = r_out_data;
  assign o_count    = r_mem_cnt + CNT_W'(r_out_valid);

endmodule

// File: rtl/instr_axi_prefetch.sv
// AXI4 burst-read prefetcher streaming N_INSTR words from instruction BRAM to the decoder.
// Optional macro INSTR_FETCH_ERR_EN: sticky FETCH_ERR port, run aborts on a non-OKAY RRESP.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for a start edge
// ST_ADDR  | waiting for FIFO space, then presenting one burst on AR
// ST_DATA  | accepting beats of the single outstanding burst
// ST_DRAIN | all bursts issued, waiting for the decoder to empty the FIFO
// ST_DONE  | run complete (or aborted), STOP_SIGNAL high until next start
module instr_axi_prefetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                N_INSTR    = 512,
  parameter int                BURST_LEN  = 16,
  parameter int                FIFO_DEPTH = 32
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                START_SIGNAL,
  output logic                STOP_SIGNAL,
  instr_axi_prefetch_if.master m_axi,
  output logic [DATA_W-1:0]   INSTR_DATA,
  output logic                INSTR_VALID,
  input  logic                INSTR_READY
`ifdef INSTR_FETCH_ERR_EN
  ,
  output logic                FETCH_ERR
`endif
);
  localparam int CNT_W  = cnt_width(N_INSTR);
  localparam int FCNT_W = cnt_width(FIFO_DEPTH);
  localparam int BYTES  = DATA_W / 8;

  fetch_state_e      r_state, w_state_nxt;
  logic              r_start, r_start_d;
  logic              w_start_edge, w_launch;
  logic [CNT_W-1:0]  r_remain;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic              r_arvalid;
  int                w_beats, w_free;
  logic [FCNT_W-1:0] w_fifo_cnt;
  logic              w_ar_hs, w_r_hs, w_last, w_err_any, w_fifo_wr, w_flush;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_start   <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_start   <= START_SIGNAL;
      r_start_d <= r_start;
    end
  end

  assign w_start_edge = r_start & ~r_start_d;
  assign w_launch     = w_start_edge & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  assign w_beats = (int'(r_remain) >= BURST_LEN) ? BURST_LEN : int'(r_remain);
  assign w_free  = FIFO_DEPTH - int'(w_fifo_cnt);
  assign w_ar_hs = r_arvalid & m_axi.arready;
  assign w_r_hs  = (r_state == ST_DATA) & m_axi.rvalid;
  assign w_last  = w_r_hs & m_axi.rlast;

`ifdef INSTR_FETCH_ERR_EN
  logic r_err, w_beat_err;
  assign w_beat_err = w_r_hs & (m_axi.rresp != RESP_OKAY);
  assign w_err_any  = r_err | w_beat_err;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)           r_err <= 1'b0;
    else if (w_launch)   r_err <= 1'b0;
    else if (w_beat_err) r_err <= 1'b1;
  end

  assign FETCH_ERR = r_err;
`else
  logic w_unused_rresp;
  assign w_unused_rresp = ^m_axi.rresp;
  assign w_err_any      = 1'b0;
`endif

  // Once a burst has gone bad, its remaining beats are taken but never stored.
  assign w_fifo_wr = w_r_hs & ~w_err_any;
  assign w_flush   = w_launch | (w_last & w_err_any);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start_edge) w_state_nxt = ST_ADDR;
      ST_ADDR:          if (w_ar_hs) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_last) begin
          if (w_err_any)           w_state_nxt = ST_DONE;
          else if (r_remain == '0) w_state_nxt = ST_DRAIN;
          else                     w_state_nxt = ST_ADDR;
        end
      end
      ST_DRAIN:         if (w_fifo_cnt == '0) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // AR fields are loaded only while ARVALID is low, so they hold until accepted.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_arvalid <= 1'b0;
      r_araddr  <= BASE_ADDR;
      r_arlen   <= '0;
      r_remain  <= '0;
    end else if (w_launch) begin
      r_arvalid <= 1'b0;
      r_araddr  <= BASE_ADDR;
      r_arlen   <= '0;
      r_remain  <= CNT_W'(N_INSTR);
    end else if (r_state == ST_ADDR) begin
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_remain  <= r_remain - CNT_W'(int'(r_arlen) + 1);
        r_araddr  <= r_araddr + ADDR_W'((int'(r_arlen) + 1) * BYTES);
      end else if (!r_arvalid && (w_free >= w_beats)) begin
        r_arvalid <= 1'b1;
        r_arlen   <= 8'(w_beats - 1);
      end
    end
  end

  assign m_axi.araddr  = r_araddr;
  assign m_axi.arlen   = r_arlen;
  assign m_axi.arsize  = axi_size(DATA_W);
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = (r_state == ST_DATA);
  assign STOP_SIGNAL   = (r_state == ST_DONE);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RSTN),
    .i_flush    (w_flush),
    .i_wr_en    (w_fifo_wr),
    .i_wr_data  (m_axi.rdata),
    .o_rd_valid (INSTR_VALID),
    .o_rd_data  (INSTR_DATA),
    .i_rd_ready (INSTR_READY),
    .o_count    (w_fifo_cnt)
  );

endmodule

// File: tb/tb_instr_axi_prefetch.sv
// Scoreboard bench for instr_axi_prefetch with a BRAM-like AXI read slave.
`timescale 1ns/1ps
module tb_instr_axi_prefetch;
  localparam int          ADDR_W     = 32;
  localparam int          DATA_W     = 32;
  localparam logic [31:0] BASE_ADDR  = 32'h0;
  localparam int          N_INSTR    = 69;
  localparam int          BURST_LEN  = 16;
  localparam int          FIFO_DEPTH = 32;
  localparam int          N_BURSTS   = (N_INSTR + BURST_LEN - 1) / BURST_LEN;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              START_SIGNAL = 1'b0;
  logic              STOP_SIGNAL;
  logic [DATA_W-1:0] INSTR_DATA;
  logic              INSTR_VALID;
  logic              INSTR_READY = 1'b0;
`ifdef INSTR_FETCH_ERR_EN
  logic              FETCH_ERR;
`endif

  instr_axi_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  instr_axi_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR),
    .N_INSTR(N_INSTR), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .START_SIGNAL (START_SIGNAL),
    .STOP_SIGNAL  (STOP_SIGNAL),
    .m_axi        (axi),
    .INSTR_DATA   (INSTR_DATA),
    .INSTR_VALID  (INSTR_VALID),
    .INSTR_READY  (INSTR_READY)
`ifdef INSTR_FETCH_ERR_EN
    ,
    .FETCH_ERR    (FETCH_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [39:0] exp_ar_q[$];
  int          ar_cnt = 0, beats_acc = 0, last_hs_cyc = 0;
  int          err_burst = -1, err_beat = 0;
  logic [7:0]  salt = 8'h00;
  bit          rdy_en = 1'b0, ar_rand = 1'b0;
  bit          burst_active = 1'b0;
  logic [31:0] b_addr = '0;
  int          b_len = 0, b_beat = 0;
  bit          f_ar = 1'b0, f_r = 1'b0, f_i = 1'b0;
  logic [39:0] cap_ar;
  logic [2:0]  cap_size;
  logic [1:0]  cap_burst;
  logic [31:0] cap_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input int idx, input logic [7:0] s);
    return {s, 8'hA5, idx[15:0]};
  endfunction

  task automatic push_run(input int n_words, input int n_bursts);
    int rem, len;
    for (int i = 0; i < n_words; i++) exp_q.push_back(word(i, salt));
    for (int b = 0; b < n_bursts; b++) begin
      rem = N_INSTR - b * BURST_LEN;
      len = ((rem < BURST_LEN) ? rem : BURST_LEN) - 1;
      exp_ar_q.push_back({BASE_ADDR + 32'(b * BURST_LEN * (DATA_W / 8)), 8'(len)});
    end
  endtask

  // AXI slave + decoder sink; handshakes seen at one negedge completed at the following posedge.
  initial begin
    logic [39:0] e_ar;
    logic [31:0] e_d;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    axi.rdata = '0; axi.rresp = 2'b00;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        f_ar = 1'b0; f_r = 1'b0; f_i = 1'b0; burst_active = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        INSTR_READY = 1'b0;
        continue;
      end
      if (f_ar) begin
        e_ar = (exp_ar_q.size() != 0) ? exp_ar_q.pop_front() : 40'hFF_FFFF_FFFF;
        check("ar_addr_len", cap_ar, e_ar);
        check("ar_size", cap_size, 3'd2);
        check("ar_burst", cap_burst, 2'b01);
        burst_active = 1'b1;
        b_addr = cap_ar[39:8];
        b_len  = int'(cap_ar[7:0]);
        b_beat = 0;
        ar_cnt++;
      end
      if (f_r) begin
        beats_acc++;
        b_beat++;
        if (b_beat > b_len) burst_active = 1'b0;
      end
      if (f_i) begin
        e_d = (exp_q.size() != 0) ? exp_q.pop_front() : ~cap_data;
        check("instr_data", cap_data, e_d);
        last_hs_cyc = cyc;
      end
      axi.arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (burst_active) begin
        axi.rvalid = 1'b1;
        axi.rdata  = word(int'((b_addr - BASE_ADDR) >> 2) + b_beat, salt);
        axi.rlast  = (b_beat == b_len);
        axi.rresp  = ((ar_cnt - 1 == err_burst) && (b_beat == err_beat)) ? 2'b10 : 2'b00;
      end else begin
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
      end
      INSTR_READY = rdy_en;
      #1;
      f_ar = axi.arvalid && axi.arready;
      f_r  = axi.rvalid && axi.rready;
      f_i  = INSTR_VALID && INSTR_READY;
      cap_ar    = {axi.araddr, axi.arlen};
      cap_size  = axi.arsize;
      cap_burst = axi.arburst;
      cap_data  = INSTR_DATA;
    end
  end

  task automatic wait_stop(input int budget, input bit chk_lat);
    int n = 0;
    while (!STOP_SIGNAL && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("stop_reached", STOP_SIGNAL, 1'b1);
    if (chk_lat) check("stop_latency", cyc, last_hs_cyc + 1);
    repeat (3) @(negedge CLK);
    check("instr_left", exp_q.size(), 0);
    check("ar_left", exp_ar_q.size(), 0);
  endtask

  task automatic new_start(input logic [7:0] s);
    START_SIGNAL = 1'b0;
    repeat (3) @(negedge CLK);
    salt = s;
    ar_cnt = 0;
    beats_acc = 0;
    START_SIGNAL = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_stop", STOP_SIGNAL, 1'b0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_araddr", axi.araddr, BASE_ADDR);
    check("rst_arlen", axi.arlen, 8'd0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_ivalid", INSTR_VALID, 1'b0);
    check("rst_idata", INSTR_DATA, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    // Run 1: start-to-ARVALID latency, then a full run with the sink always ready.
    salt = 8'h11; rdy_en = 1'b1;
    push_run(N_INSTR, N_BURSTS);
    START_SIGNAL = 1'b1;
    @(posedge CLK); #1;
    check("arvalid_k", axi.arvalid, 1'b0);
    @(posedge CLK); #1;
    check("arvalid_k1", axi.arvalid, 1'b0);
    @(posedge CLK); #1;
    check("arvalid_k2", axi.arvalid, 1'b1);
    wait_stop(2000, 1'b1);

    // Run 2: restart from DONE, stalled decoder, mid-run start toggle, random ARREADY.
    START_SIGNAL = 1'b0;
    repeat (3) @(negedge CLK);
    check("stop_held", STOP_SIGNAL, 1'b1);
    rdy_en = 1'b0; ar_rand = 1'b1;
    salt = 8'h22;
    push_run(N_INSTR, N_BURSTS);
    new_start(8'h22);
    repeat (4) @(negedge CLK);
    check("stop_cleared", STOP_SIGNAL, 1'b0);
    repeat (100) @(negedge CLK);
    START_SIGNAL = 1'b0;
    repeat (3) @(negedge CLK);
    START_SIGNAL = 1'b1;
    repeat (93) @(negedge CLK);
    check("stall_ar_cnt", ar_cnt, 2);
    check("stall_arvalid", axi.arvalid, 1'b0);
    check("stall_ivalid", INSTR_VALID, 1'b1);
    rdy_en = 1'b1;
    wait_stop(3000, 1'b1);
    ar_rand = 1'b0;

    // Run 3: reset while beat 7 of the first burst is pending, then a clean run.
    salt = 8'h33;
    push_run(N_INSTR, N_BURSTS);
    new_start(8'h33);
    n = 0;
    while (beats_acc < 7 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("beat7_reached", beats_acc, 7);
    #2;
    RSTN = 1'b0;
    START_SIGNAL = 1'b0;
    #1;
    check("mid_rst_arvalid", axi.arvalid, 1'b0);
    check("mid_rst_araddr", axi.araddr, BASE_ADDR);
    check("mid_rst_arlen", axi.arlen, 8'd0);
    check("mid_rst_rready", axi.rready, 1'b0);
    check("mid_rst_ivalid", INSTR_VALID, 1'b0);
    check("mid_rst_idata", INSTR_DATA, 32'd0);
    check("mid_rst_stop", STOP_SIGNAL, 1'b0);
    exp_q.delete();
    exp_ar_q.delete();
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    salt = 8'h44;
    push_run(N_INSTR, N_BURSTS);
    new_start(8'h44);
    wait_stop(2000, 1'b1);

`ifdef INSTR_FETCH_ERR_EN
    // Run 4: SLVERR on beat 2 of the third burst aborts the run.
    err_burst = 2; err_beat = 2;
    salt = 8'h55;
    push_run(2 * BURST_LEN + 2, 3);
    new_start(8'h55);
    wait_stop(2000, 1'b0);
    repeat (20) @(negedge CLK);
    check("err_flag", FETCH_ERR, 1'b1);
    check("err_ar_cnt", ar_cnt, 3);
    check("err_ivalid", INSTR_VALID, 1'b0);
    check("err_stop", STOP_SIGNAL, 1'b1);
    err_burst = -1;
    salt = 8'h66;
    push_run(N_INSTR, N_BURSTS);
    new_start(8'h66);
    repeat (4) @(negedge CLK);
    check("err_cleared", FETCH_ERR, 1'b0);
    wait_stop(2000, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_axi_prefetch.md
# instr_axi_prefetch

Parametrised AXI4 burst read master that streams a program of N_INSTR words from the instruction BRAM into a prefetch FIFO feeding the SIMD decoder. Successor to the single-beat PL BRAM fetch path: configurable data width, burst length, FIFO depth and program length, with flow control. Started by the GPIO START_SIGNAL; raises STOP_SIGNAL once every instruction has been handed to the decoder.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 32, instruction/AXI data width (32, 64 or 128)
- BASE_ADDR, 0, byte address of instruction 0; aligned to BURST_LEN*DATA_W/8
- N_INSTR, 512, instructions per program (≥1)
- BURST_LEN, 16, max beats per burst, power of two, 1..256
- FIFO_DEPTH, 32, prefetch FIFO entries, power of two, ≥ BURST_LEN
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- START_SIGNAL  in  1  GPIO start level; rising edge launches a run
- STOP_SIGNAL  out  1  high when run complete, held until next start
- M_AXI_ARADDR / ARLEN / ARSIZE / ARBURST  out  ADDR_W/8/3/2  read address; ARSIZE=log2(DATA_W/8), ARBURST=INCR
- M_AXI_ARVALID  out  1 ; M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DATA_W ; M_AXI_RRESP  in  2 ; M_AXI_RLAST  in  1 ; M_AXI_RVALID  in  1 ; M_AXI_RREADY  out  1
- INSTR_DATA  out  DATA_W  instruction to decoder
- INSTR_VALID  out  1 ; INSTR_READY  in  1  valid/ready stream handshake
- FETCH_ERR  out  1  (only with INSTR_FETCH_ERR_EN) sticky error flag

## Operation
- FSM states: IDLE, ADDR, DATA, DRAIN, DONE.
- START_SIGNAL registered once; edge = current high & previous low. Edge in IDLE or DONE: clear beat counter, FIFO, STOP_SIGNAL; go ADDR. Edge in ADDR/DATA/DRAIN ignored.
- ADDR: ARVALID high only when FIFO free entries ≥ this burst's beat count. ARADDR = BASE_ADDR + issued*(DATA_W/8). ARLEN = min(BURST_LEN, N_INSTR−issued)−1. AR fields stable while ARVALID && !ARREADY. On ARREADY → DATA.
- One burst outstanding at a time. DATA: RREADY=1 (space already reserved); each RVALID beat written to FIFO. On RLAST beat: all issued → DRAIN, else → ADDR.
- DRAIN: FIFO empty → DONE; STOP_SIGNAL=1 in DONE.
- Counters sized $clog2(N_INSTR+1); no address wrap; bursts never cross 4 KB given BASE_ADDR alignment.
- FIFO write and read in same cycle: both proceed; full FIFO never written (guaranteed by reservation).

## Timing
- Reset values: STOP_SIGNAL=0, ARVALID=0, ARADDR=BASE_ADDR, ARLEN=0, RREADY=0, INSTR_VALID=0, INSTR_DATA=0, FETCH_ERR=0; FSM IDLE.
- START_SIGNAL rise sampled at edge k → ARVALID high at edge k+2.
- Accepted R beat at edge t → INSTR_VALID high after edge t+1 (registered FIFO output).
- Last INSTR_VALID&&INSTR_READY at edge t → STOP_SIGNAL high after edge t+1.
- RSTN low mid-run: immediate return to reset values; outstanding AXI transaction abandoned (interconnect reset together).

## Configuration
- INSTR_FETCH_ERR_EN defined: any RRESP≠OKAY sets FETCH_ERR; remaining beats of that burst accepted and discarded, no further bursts, FIFO flushed, → DONE with STOP_SIGNAL=1. FETCH_ERR cleared by next start edge.
- Undefined: FETCH_ERR port absent, RRESP ignored, data always stored.

## Structure
- Package instr_fetch_pkg: state enum, AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00), width helper functions.
- Sub-module sync_fifo (DATA_W, FIFO_DEPTH; count output used for reservation).

## Test plan
- N_INSTR=512, BURST_LEN=16, ARREADY/RVALID always high, INSTR_READY=1 → 32 bursts, ARADDR 0x000,0x040..0x7C0, 512 words in order, STOP_SIGNAL high after last handshake.
- N_INSTR=37, BURST_LEN=16 → ARLEN 15,15,4; exactly 37 instructions; STOP high.
- INSTR_READY=0 for 200 cycles, FIFO_DEPTH=32 → only 2 bursts issued, ARVALID low until space, no data lost after release.
- START_SIGNAL toggled mid-run → ignored; second rising edge after STOP → STOP drops, run repeats from BASE_ADDR.
- RSTN low during DATA beat 7 → all outputs at reset values next cycle; fresh start completes normally.
- INSTR_FETCH_ERR_EN, RRESP=SLVERR on burst 3 beat 2 → FETCH_ERR=1, burst 3 drained, no burst 4, STOP high.
